// File: rtl/conv_tile_sequencer.sv
// Operand/result sequencer for a 3x3-kernel, 4x4-tile convolution datapath.
// Optional weight retention between frames is enabled by defining CNN_SEQ_KEEP_WEIGHTS_EN.
module conv_tile_sequencer #(
  parameter int DP_LATENCY = 3,
  parameter int OUT_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  reload_w,
  output logic [71:0]           dp_a,
  output logic [71:0]           dp_b,
  output logic [127:0]          dp_u,
  output logic [127:0]          dp_i,
  input  logic [16*OUT_W-1:0]   dp_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_LOAD_A, S_LOAD_B, S_LOAD_U, S_LOAD_I, S_WAIT, S_CAPTURE, S_DRAIN
  } state_t;

  state_t                state_q, state_d, next_frame;
  logic [4:0]            cnt_q, cnt_d;
  logic [3:0]            lat_q, lat_d;
  logic [71:0]           a_q, b_q;
  logic [127:0]          u_q, i_q;
  logic [16*OUT_W-1:0]   res_q;
  logic                  in_ready_q, out_valid_q, out_last_q, busy_q;

`ifdef CNN_SEQ_KEEP_WEIGHTS_EN
  logic wv_q, reload_q;
  assign next_frame = (wv_q && !reload_q) ? S_LOAD_U : S_LOAD_A;
`else
  logic unused_reload;
  assign unused_reload = reload_w;
  assign next_frame    = S_LOAD_A;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (in_valid) begin
          if (cnt_q == 5'd8) begin
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_LOAD_U;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_LOAD_U, S_LOAD_I: begin
        if (in_valid) begin
          if (cnt_q == 5'd15) begin
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_U) ? S_LOAD_I : S_WAIT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 4'(DP_LATENCY - 1)) begin
          lat_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == 5'd15) begin
            cnt_d   = '0;
            state_d = next_frame;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        lat_d   = '0;
        state_d = S_LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      lat_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      u_q         <= '0;
      i_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CNN_SEQ_KEEP_WEIGHTS_EN
      wv_q        <= 1'b0;
      reload_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      // Handshake/status outputs are registered from the next state
      in_ready_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) ||
                     (state_d == S_LOAD_U) || (state_d == S_LOAD_I);
      out_valid_q <= (state_d == S_DRAIN);
      out_last_q  <= (state_d == S_DRAIN) && (cnt_d == 5'd15);
      busy_q      <= (state_d == S_WAIT) || (state_d == S_CAPTURE) || (state_d == S_DRAIN);
      if (in_valid) begin
        case (state_q)
          S_LOAD_A: a_q[{cnt_q, 3'b000} +: 8] <= in_data;
          S_LOAD_B: b_q[{cnt_q, 3'b000} +: 8] <= in_data;
          S_LOAD_U: u_q[{cnt_q, 3'b000} +: 8] <= in_data;
          S_LOAD_I: i_q[{cnt_q, 3'b000} +: 8] <= in_data;
          default: ;
        endcase
      end
      if (state_q == S_CAPTURE) res_q <= dp_y;
`ifdef CNN_SEQ_KEEP_WEIGHTS_EN
      if (state_q == S_LOAD_B && in_valid && cnt_q == 5'd8) wv_q <= 1'b1;
      // A frame that starts at LOAD_A reloads the weights anyway, so it retires the request
      if (state_d == S_LOAD_A && state_q != S_LOAD_A) reload_q <= 1'b0;
      else if (reload_w)                              reload_q <= 1'b1;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_u      = u_q;
  assign dp_i      = i_q;
  assign out_data  = res_q[cnt_q[3:0]*OUT_W +: OUT_W];

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed self-checking bench for conv_tile_sequencer (default build, DP_LATENCY=3, OUT_W=9).
module tb_conv_tile_sequencer;
  localparam int OUT_W = 9;

  logic                clk = 1'b0;
  logic                rst_n, in_valid, reload_w, out_ready;
  logic [7:0]          in_data;
  logic                in_ready, out_valid, out_last, busy;
  logic [71:0]         dp_a, dp_b;
  logic [127:0]        dp_u, dp_i;
  logic [16*OUT_W-1:0] dp_y;
  logic [OUT_W-1:0]    out_data;

  int checks = 0;
  int errors = 0;

  conv_tile_sequencer #(.DP_LATENCY(3), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reload_w(reload_w), .dp_a(dp_a), .dp_b(dp_b), .dp_u(dp_u), .dp_i(dp_i), .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] exp_bank(input int base, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = 8'(base + k);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input int mul, input int add);
    for (int n = 1; n <= 16; n++) dp_y[OUT_W*(n-1) +: OUT_W] = OUT_W'(mul * n + add);
  endtask

  // Offers consecutive bytes base, base+1, ... while in_ready stays high; returns bytes accepted.
  task automatic feed_count(input int base, output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (in_ready !== 1'b1) break;
      in_data  = 8'(base + n);
      in_valid = 1'b1;
      cyc();
      n++;
    end
    in_valid = 1'b0;
  endtask

  // Drains one frame with out_ready high; returns words transferred up to and including out_last.
  task automatic drain_all(output int words);
    logic seen_last;
    words     = 0;
    seen_last = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && !seen_last; c++) begin
      if (out_valid === 1'b1) begin
        words++;
        if (out_last === 1'b1) seen_last = 1'b1;
      end
      cyc();
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < ncyc; c++) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload_w = 1'b0; out_ready = 1'b0;
    set_y(1, 'h100);
    do_reset(2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_valid, out_last, busy} !== 3'b000) begin errors++; $display("FAIL reset_outs: got %b want 000", {out_valid, out_last, busy}); end
    checks++; if ({dp_a, dp_b, dp_u, dp_i} !== '0) begin errors++; $display("FAIL reset_banks: got %h want 0", {dp_a, dp_b, dp_u, dp_i}); end
    in_data = 8'hAA;
    for (int c = 0; c < 3; c++) cyc();
    checks++; if (dp_a !== 72'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_no_advance: got a=%h rdy=%b want 0/1", dp_a, in_ready); end
  endtask

  task automatic test_load();
    logic [127:0] e;
    int rdy_bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready !== 1'b1) rdy_bad++;
      in_data = 8'(k); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL load_ready_high: got %0d low cycles want 0", rdy_bad); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL load_ready_drop: got rdy=%b busy=%b want 0/1", in_ready, busy); end
    checks++; if (dp_a[7:0] !== 8'h00 || dp_a[71:64] !== 8'h08) begin errors++; $display("FAIL load_a_ends: got %h want 08..00", dp_a); end
    checks++; if (dp_b[7:0] !== 8'h09 || dp_u[7:0] !== 8'h12 || dp_i[127:120] !== 8'h31) begin errors++; $display("FAIL load_spot: got b0=%h u0=%h i15=%h want 09/12/31", dp_b[7:0], dp_u[7:0], dp_i[127:120]); end
    e = exp_bank(0, 9);
    checks++; if (dp_a !== e[71:0]) begin errors++; $display("FAIL load_a: got %h want %h", dp_a, e[71:0]); end
    e = exp_bank(9, 9);
    checks++; if (dp_b !== e[71:0]) begin errors++; $display("FAIL load_b: got %h want %h", dp_b, e[71:0]); end
    checks++; if (dp_u !== exp_bank(18, 16)) begin errors++; $display("FAIL load_u: got %h want %h", dp_u, exp_bank(18, 16)); end
    checks++; if (dp_i !== exp_bank(34, 16)) begin errors++; $display("FAIL load_i: got %h want %h", dp_i, exp_bank(34, 16)); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++; if (out_valid !== (c == 4)) begin errors++; $display("FAIL latency_c%0d: got out_valid=%b want %b", c, out_valid, (c == 4)); end
    end
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(k + 'h100) || out_last !== (k == 16)) begin
        errors++; $display("FAIL drain_w%0d: got v=%b d=%h l=%b want 1/%h/%b", k, out_valid, out_data, out_last, OUT_W'(k + 'h100), (k == 16));
      end
      cyc();
    end
    checks++; if ({out_valid, out_last, busy, in_ready} !== 4'b0001) begin errors++; $display("FAIL drain_done: got %b want 0001", {out_valid, out_last, busy, in_ready}); end
  endtask

  task automatic test_stall();
    int n, idx, c;
    logic [3:0] pat = 4'b1001;
    set_y(-7, 'h1F0);
    out_ready = 1'b0;
    feed_count('h80, n);
    checks++; if (n != 50 || dp_a[7:0] !== 8'h80) begin errors++; $display("FAIL stall_load: got n=%0d a0=%h want 50/80", n, dp_a[7:0]); end
    for (c = 0; c < 10 && out_valid !== 1'b1; c++) cyc();
    for (c = 0; c < 3; c++) cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h1E9) begin errors++; $display("FAIL stall_hold: got v=%b d=%h want 1/1e9", out_valid, out_data); end
    idx = 0;
    c   = 0;
    while (idx < 16 && c < 80) begin
      out_ready = pat[c % 4];
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'('h1F0 - 7*(idx+1)) || out_last !== (idx == 15)) begin
        errors++; $display("FAIL stall_w%0d: got v=%b d=%h l=%b want 1/%h/%b", idx+1, out_valid, out_data, out_last, OUT_W'('h1F0 - 7*(idx+1)), (idx == 15));
      end
      if (out_ready) idx++;
      cyc();
      c++;
    end
    out_ready = 1'b1;
    checks++; if (idx != 16 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_end: got idx=%0d v=%b rdy=%b want 16/0/1", idx, out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 20; k++) begin
      in_data = 8'(k + 'h20); in_valid = 1'b1;
      cyc();
    end
    do_reset(1);
    checks++; if ({dp_a, dp_b, dp_u, dp_i} !== '0) begin errors++; $display("FAIL midrst_banks: got %h want 0", {dp_a, dp_b, dp_u, dp_i}); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ready: got rdy=%b busy=%b want 1/0", in_ready, busy); end
    in_data = 8'h55; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++; if (dp_a !== 72'h55 || dp_b !== 72'h0) begin errors++; $display("FAIL midrst_first: got a=%h b=%h want 55/0", dp_a, dp_b); end
  endtask

  task automatic test_throttle();
    int edges = 0;
    int fall  = -1;
    logic [127:0] e;
    do_reset(1);
    for (int k = 0; k < 50; k++) begin
      for (int p = 0; p < 3; p++) begin
        in_valid = (p == 0);
        in_data  = (p == 0) ? 8'(k) : 8'hEE;
        cyc();
        edges++;
        if (fall < 0 && in_ready === 1'b0) fall = edges;
      end
    end
    in_valid = 1'b0;
    checks++; if (fall != 148) begin errors++; $display("FAIL throttle_time: got ready drop at edge %0d want 148", fall); end
    e = exp_bank(0, 9);
    checks++; if (dp_a !== e[71:0]) begin errors++; $display("FAIL throttle_a: got %h want %h", dp_a, e[71:0]); end
    e = exp_bank(9, 9);
    checks++; if (dp_b !== e[71:0]) begin errors++; $display("FAIL throttle_b: got %h want %h", dp_b, e[71:0]); end
    checks++; if (dp_u !== exp_bank(18, 16) || dp_i !== exp_bank(34, 16)) begin errors++; $display("FAIL throttle_ui: got u=%h i=%h", dp_u, dp_i); end
  endtask

  task automatic test_frames();
    int n, w;
    logic [71:0] a_prev, b_prev;
    set_y(1, 'h100);
    do_reset(1);
    feed_count(0, n);
    drain_all(w);
    checks++; if (n != 50 || w != 16) begin errors++; $display("FAIL frame1: got bytes=%0d words=%0d want 50/16", n, w); end
    a_prev = dp_a;
    b_prev = dp_b;
    feed_count('h40, n);
`ifdef CNN_SEQ_KEEP_WEIGHTS_EN
    checks++; if (n != 32 || dp_a !== a_prev || dp_b !== b_prev) begin errors++; $display("FAIL frame2_keep: got bytes=%0d a=%h want 32/%h", n, dp_a, a_prev); end
`else
    checks++; if (n != 50 || dp_a[7:0] !== 8'h40 || dp_b === b_prev) begin errors++; $display("FAIL frame2_full: got bytes=%0d a0=%h want 50/40", n, dp_a[7:0]); end
`endif
    reload_w = 1'b1;
    cyc();
    reload_w = 1'b0;
    drain_all(w);
    feed_count('h90, n);
    checks++; if (n != 50 || dp_a[7:0] !== 8'h90) begin errors++; $display("FAIL frame3_full: got bytes=%0d a0=%h want 50/90", n, dp_a[7:0]); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_drain();
    test_stall();
    test_reset_mid();
    test_throttle();
    test_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
